// File: rtl/hazard_stall_scoreboard_if.sv
// Decode-stage interlock bus: ID instruction fields in, stall/bubble/status out.
// The master side drives the decoded instruction; the slave side is the scoreboard.
interface hazard_stall_scoreboard_if #(
    parameter int STAT_W = 32
);
    logic              id_valid;
    logic [4:0]        id_read1;
    logic [4:0]        id_read2;
    logic              id_reg_write;
    logic [4:0]        id_write_reg;
    logic              flush;
    logic              stall;
    logic              bubble;
    logic [31:0]       busy_vec;
    logic [STAT_W-1:0] stall_count;

    modport master (
        output id_valid, id_read1, id_read2, id_reg_write, id_write_reg, flush,
        input  stall, bubble, busy_vec, stall_count
    );

    modport slave (
        input  id_valid, id_read1, id_read2, id_reg_write, id_write_reg, flush,
        output stall, bubble, busy_vec, stall_count
    );
endinterface

// File: rtl/hazard_stall_scoreboard.sv
// Decode-stage interlock for a 5-stage pipeline without forwarding: a per-register
// countdown of in-flight writes stalls readers until the producer reaches WB.
module hazard_stall_scoreboard #(
    parameter int DIST   = 2,
    parameter int CNT_W  = 3,
    parameter int STAT_W = 32
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    hazard_stall_scoreboard_if.slave  bus
);
    logic [31:0]       busy;
    logic              hazard;
    logic              issue;
    logic              load_ok;
    logic [4:0]        last_dest_q;
    logic              last_vld_q;
    logic [STAT_W-1:0] stall_count_q;
    logic [STAT_W-1:0] stall_count_d;

    // $0 has no counter, so it can never look busy.
    assign busy[0] = 1'b0;

    assign hazard = bus.id_valid &
                    (((bus.id_read1 != 5'd0) & busy[bus.id_read1]) |
                     ((bus.id_read2 != 5'd0) & busy[bus.id_read2]));
    assign issue   = bus.id_valid & ~hazard & ~bus.flush;
    assign load_ok = issue & bus.id_reg_write & (bus.id_write_reg != 5'd0);

    assign bus.stall       = hazard & ~bus.flush;
    assign bus.bubble      = hazard | bus.flush;
    assign bus.busy_vec    = busy;
    assign bus.stall_count = stall_count_q;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            assign busy[gi] = |cnt_q;

            // A new issue outranks cancelling the squashed producer, which outranks aging.
            always_comb begin
                cnt_d = cnt_q;
                if (load_ok && (bus.id_write_reg == 5'(gi))) begin
                    cnt_d = CNT_W'(DIST);
                end else if (bus.flush && last_vld_q && (last_dest_q == 5'(gi))) begin
                    cnt_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge Clk) begin
                if (!Rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        stall_count_d = stall_count_q;
        if (bus.stall && (stall_count_q != {STAT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            last_dest_q   <= 5'd0;
            last_vld_q    <= 1'b0;
            stall_count_q <= '0;
        end else begin
            last_dest_q   <= bus.id_write_reg;
            last_vld_q    <= load_ok;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_hazard_stall_scoreboard.sv
// Directed bench for hazard_stall_scoreboard: expected outputs are queued as each
// step is driven and checked mid-cycle; a second instance has a 2-bit stall counter.
module tb_hazard_stall_scoreboard;
    logic       Clk;
    logic       Rst_n;
    logic       v, fl, rw;
    logic [4:0] r1, r2, wd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        stall;
        logic        bubble;
        logic [31:0] busy;
        logic [31:0] scnt;
        logic [31:0] scnt_sat;
    } exp_t;

    exp_t exp_q[$];

    hazard_stall_scoreboard_if #(.STAT_W(32)) bus_main ();
    hazard_stall_scoreboard_if #(.STAT_W(2))  bus_sat ();

    assign bus_main.id_valid     = v;
    assign bus_main.id_read1     = r1;
    assign bus_main.id_read2     = r2;
    assign bus_main.id_reg_write = rw;
    assign bus_main.id_write_reg = wd;
    assign bus_main.flush        = fl;
    assign bus_sat.id_valid      = v;
    assign bus_sat.id_read1      = r1;
    assign bus_sat.id_read2      = r2;
    assign bus_sat.id_reg_write  = rw;
    assign bus_sat.id_write_reg  = wd;
    assign bus_sat.flush         = fl;

    hazard_stall_scoreboard #(.DIST(2), .CNT_W(3), .STAT_W(32)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_main)
    );

    hazard_stall_scoreboard #(.DIST(2), .CNT_W(3), .STAT_W(2)) dut_sat (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus_sat)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, expv);
        end
    endtask

    // Drive one cycle of ID inputs, queue what the outputs must be, then check mid-cycle.
    task automatic step(input string tag, input logic rst_n_in,
                        input logic vi, input logic [4:0] r1i, input logic [4:0] r2i,
                        input logic rwi, input logic [4:0] wdi, input logic fli,
                        input logic e_stall, input logic e_bubble,
                        input logic [31:0] e_busy, input logic [31:0] e_scnt);
        exp_t e;
        exp_t got;
        @(posedge Clk);
        #1;
        Rst_n = rst_n_in;
        v = vi; r1 = r1i; r2 = r2i; rw = rwi; wd = wdi; fl = fli;
        e.tag      = tag;
        e.stall    = e_stall;
        e.bubble   = e_bubble;
        e.busy     = e_busy;
        e.scnt     = e_scnt;
        e.scnt_sat = (e_scnt > 32'd3) ? 32'd3 : e_scnt;
        exp_q.push_back(e);
        @(negedge Clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            got = exp_q.pop_front();
            check(got.tag, "stall",    32'(bus_main.stall),       32'(got.stall));
            check(got.tag, "bubble",   32'(bus_main.bubble),      32'(got.bubble));
            check(got.tag, "busy_vec", bus_main.busy_vec,         got.busy);
            check(got.tag, "count",    bus_main.stall_count,      got.scnt);
            check(got.tag, "sat",      32'(bus_sat.stall_count),  got.scnt_sat);
            $display("step %-12s stall=%0b bubble=%0b busy=%08h count=%0d sat=%0d",
                     got.tag, bus_main.stall, bus_main.bubble, bus_main.busy_vec,
                     bus_main.stall_count, bus_sat.stall_count);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        v = 1'b0; r1 = 5'd0; r2 = 5'd0; rw = 1'b0; wd = 5'd0; fl = 1'b0;
        repeat (2) begin
            @(posedge Clk);
            #1;
            v  = 1'($urandom);
            r1 = 5'($urandom);
            r2 = 5'($urandom);
            rw = 1'($urandom);
            wd = 5'($urandom);
            fl = 1'($urandom);
        end

        //    tag            rst  v   r1     r2     rw  wd     fl   stall bub busy          count
        step("rst_idle",     1,   0,  5'd0,  5'd0,  0,  5'd0,  0,   0,    0,  32'h0,        0);
        // RAW: add $8,$9,$10 then add $11,$8,$12
        step("raw_prod",     1,   1,  5'd9,  5'd10, 1,  5'd8,  0,   0,    0,  32'h0,        0);
        step("raw_stall1",   1,   1,  5'd8,  5'd12, 1,  5'd11, 0,   1,    1,  32'h100,      0);
        step("raw_stall2",   1,   1,  5'd8,  5'd12, 1,  5'd11, 0,   1,    1,  32'h100,      1);
        step("raw_issue",    1,   1,  5'd8,  5'd12, 1,  5'd11, 0,   0,    0,  32'h0,        2);
        step("raw_idle1",    1,   0,  5'd0,  5'd0,  0,  5'd0,  0,   0,    0,  32'h800,      2);
        step("raw_idle2",    1,   0,  5'd0,  5'd0,  0,  5'd0,  0,   0,    0,  32'h800,      2);
        // $0 writer and reader, then independent registers
        step("zero_prod",    1,   1,  5'd0,  5'd0,  1,  5'd0,  0,   0,    0,  32'h0,        2);
        step("zero_cons",    1,   1,  5'd0,  5'd0,  0,  5'd0,  0,   0,    0,  32'h0,        2);
        step("indep_prod",   1,   1,  5'd0,  5'd0,  1,  5'd8,  0,   0,    0,  32'h0,        2);
        step("indep_cons",   1,   1,  5'd9,  5'd0,  0,  5'd0,  0,   0,    0,  32'h100,      2);
        step("indep_idle",   1,   0,  5'd0,  5'd0,  0,  5'd0,  0,   0,    0,  32'h100,      2);
        step("indep_done",   1,   0,  5'd0,  5'd0,  0,  5'd0,  0,   0,    0,  32'h0,        2);
        // Flush squashes both the reader and the producer issued last cycle
        step("fl_prod",      1,   1,  5'd0,  5'd0,  1,  5'd8,  0,   0,    0,  32'h0,        2);
        step("fl_cons",      1,   1,  5'd8,  5'd0,  1,  5'd11, 1,   0,    1,  32'h100,      2);
        step("fl_after",     1,   0,  5'd0,  5'd0,  0,  5'd0,  0,   0,    0,  32'h0,        2);
        step("fl_only",      1,   1,  5'd0,  5'd0,  1,  5'd4,  1,   0,    1,  32'h0,        2);
        step("fl_noload",    1,   0,  5'd0,  5'd0,  0,  5'd0,  0,   0,    0,  32'h0,        2);
        // Reload: the younger writer of $5 sets the stall window
        step("rl_w1",        1,   1,  5'd0,  5'd0,  1,  5'd5,  0,   0,    0,  32'h0,        2);
        step("rl_w2",        1,   1,  5'd0,  5'd0,  1,  5'd5,  0,   0,    0,  32'h20,       2);
        step("rl_stall1",    1,   1,  5'd5,  5'd0,  0,  5'd0,  0,   1,    1,  32'h20,       2);
        step("rl_stall2",    1,   1,  5'd5,  5'd0,  0,  5'd0,  0,   1,    1,  32'h20,       3);
        step("rl_issue",     1,   1,  5'd5,  5'd0,  0,  5'd0,  0,   0,    0,  32'h0,        4);
        // Second source port, and an invalid ID slot never stalls
        step("r2_prod",      1,   1,  5'd0,  5'd0,  1,  5'd17, 0,   0,    0,  32'h0,        4);
        step("r2_invalid",   1,   0,  5'd17, 5'd17, 0,  5'd0,  0,   0,    0,  32'h20000,    4);
        step("r2_stall",     1,   1,  5'd3,  5'd17, 0,  5'd0,  0,   1,    1,  32'h20000,    4);
        step("r2_issue",     1,   1,  5'd3,  5'd17, 0,  5'd0,  0,   0,    0,  32'h0,        5);
        // Reset in the middle of a stall
        step("mr_prod",      1,   1,  5'd0,  5'd0,  1,  5'd8,  0,   0,    0,  32'h0,        5);
        step("mr_stall",     0,   1,  5'd8,  5'd0,  0,  5'd0,  0,   1,    1,  32'h100,      5);
        step("mr_after",     1,   1,  5'd8,  5'd0,  0,  5'd0,  0,   0,    0,  32'h0,        0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_scoreboard.md
Name: hazard_stall_scoreboard

Overview:
- Decode-stage interlock controller for the 5-stage MIPS pipeline without forwarding.
- Tracks in-flight register writes in a per-register countdown scoreboard.
- Compares the decoding instruction's source registers (rs/rt selections from decode, 0 = none) against pending writes.
- When a match exists, stalls PC and IF/ID and injects a bubble into ID/EX until the producer reaches WB. The register file is write-first, so a same-cycle WB write is readable in ID.

Parameters:
- DIST, 2: countdown loaded at issue; the number of stall cycles for a back-to-back dependency. Range 1..7.
- CNT_W, 3: width of each scoreboard counter; must hold DIST.
- STAT_W, 32: width of the stall statistics counter.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst_n, input, 1: synchronous active-low reset.
- id_valid, input, 1: the instruction in ID is real (0 for a NOP/bubble).
- id_read1, input, 5: first source register of the ID instruction; 0 = none.
- id_read2, input, 5: second source register of the ID instruction; 0 = none.
- id_reg_write, input, 1: the ID instruction writes a register.
- id_write_reg, input, 5: destination register of the ID instruction.
- flush, input, 1: taken branch/jump resolved this cycle; squash the ID instruction and the instruction issued last cycle.
- stall, output, 1: hold PC and IF/ID.
- bubble, output, 1: load a NOP into ID/EX.
- busy_vec, output, 32: bit r = 1 when register r has a nonzero counter; bit 0 is always 0.
- stall_count, output, STAT_W: number of cycles in which stall was asserted.

Behaviour:
- State: cnt[1..31], each CNT_W bits; last_dest, 5 bits; last_vld, 1 bit; stall_count. There is no cnt[0].
- Reset (Rst_n = 0 at a rising edge): all cnt = 0, last_dest = 0, last_vld = 0, stall_count = 0. Outputs are therefore stall = 0, bubble = 0, busy_vec = 0, stall_count = 0. Reset takes priority over every other input.
- hazard (combinational): id_valid & ((id_read1 != 0 & cnt[id_read1] != 0) | (id_read2 != 0 & cnt[id_read2] != 0)).
- stall = hazard & ~flush.
- bubble = hazard | flush.
- issue = id_valid & ~hazard & ~flush.
- Per-register update each edge, in this priority order:
  - (a) If issue & id_reg_write & id_write_reg == r (r != 0): cnt[r] <= DIST.
  - (b) Else if flush & last_vld & last_dest == r: cnt[r] <= 0. This cancels the squashed producer in EX.
  - (c) Else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
  - (d) Otherwise cnt[r] holds.
- A load on a register that is already counting restarts it at DIST. The younger writer governs.
- A write to $0 never loads a counter and never causes a stall.
- last_dest <= id_write_reg and last_vld <= issue & id_reg_write & (id_write_reg != 0) every edge. While stalled, last_vld becomes 0 because the bubble carries no write.
- stall_count increments by 1 on every edge where stall = 1 and saturates at all-ones.
- Latency example with DIST = 2: the producer issues at edge e0; cnt = 2 while it is in EX and 1 while in MEM, both stall cycles. cnt = 0 when it is in WB, so the consumer issues then.
- Simultaneous events:
  - flush together with hazard: no stall, bubble = 1, no load.
  - Issue of a register being decremented: the load wins.
- Outputs are combinational from state and inputs and contain no internal loop. stall never depends on the current-cycle load.

Test Plan:
- Reset: Rst_n = 0 for 2 cycles with random inputs, then release -> busy_vec = 0, stall = 0, stall_count = 0. Assert Rst_n = 0 mid-stall -> stall = 0 on the next cycle.
- RAW dependency: issue add $8,$9,$10, then present add $11,$8,$12 -> stall = bubble = 1 for exactly 2 cycles, issue on the 3rd cycle, stall_count = 2, busy_vec[8] sequence 1,1,0.
- Independent instructions and $0: the producer writes $0, the consumer reads $0 -> no stall. Then add $8 followed by a reader of $9 only -> no stall, busy_vec = 0x100 for 2 cycles.
- Flush: issue a writer of $8, then next cycle present a reader of $8 with flush = 1 -> stall = 0, bubble = 1, cnt[8] cleared, busy_vec = 0 the following cycle.
- Reload: writers of $5 on two consecutive issues, then a reader of $5 -> stalls 2 cycles measured from the second writer, not the first.
- Saturation: STAT_W = 2, force 5 stall cycles -> stall_count stops at 3.
